// File: rtl/flipflop_pkg.sv
// Shared defaults and bus typedef for the flipflop register pipeline.
package flipflop_pkg;
   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 1;

   typedef logic [DEFAULT_WIDTH-1:0] data_t;

   typedef struct packed {
      logic  reset;
      data_t data;
   } stage_in_t;

   // Latency of a pipeline equals its stage count.
   function automatic int latency(input int depth);
      return depth;
   endfunction
endpackage

// File: rtl/flipflop_stage.sv
// One WIDTH-bit register with synchronous active-high reset to RESET_VAL.
module flipflop_stage
   import flipflop_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk) begin
      if (reset) q_q <= RESET_VAL;
      else       q_q <= d;
   end

   assign q = q_q;
endmodule

// File: rtl/flipflop.sv
// DEPTH-stage registered data pipeline; qout lags qin by DEPTH edges.
// Define FLIPFLOP_ASSERT_EN to compile in the built-in SVA checkers.
module flipflop
   import flipflop_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter int               DEPTH     = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] qin,
   output logic [WIDTH-1:0] qout
);
   if (DEPTH < 1 || WIDTH < 1) begin : g_bad_cfg
      $fatal(1, "flipflop: WIDTH (%0d) and DEPTH (%0d) must both be >= 1", WIDTH, DEPTH);
   end

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] stage_d;
      if (i == 0) begin : g_head
         assign stage_d = qin;
      end else begin : g_chain
         assign stage_d = stage_q[i-1];
      end
      flipflop_stage #(
         .WIDTH    (WIDTH),
         .RESET_VAL(RESET_VAL)
      ) u_stage (
         .clk  (clk),
         .reset(reset),
         .d    (stage_d),
         .q    (stage_q[i])
      );
   end

   assign qout = stage_q[DEPTH-1];

`ifdef FLIPFLOP_ASSERT_EN
   // 2-state trackers start at 0 in simulation without needing a reset.
   bit          seen_rst_q;
   int unsigned low_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         seen_rst_q <= 1'b1;
         low_cnt_q  <= 0;
      end else if (low_cnt_q < DEPTH) begin
         low_cnt_q  <= low_cnt_q + 1;
      end
   end

   a_reset_val: assert property (@(posedge clk) disable iff ($time == 0)
      $past(reset) |-> qout == RESET_VAL)
      else $error("flipflop: qout != RESET_VAL after reset edge at %0t", $time);

   if (DEPTH == 1) begin : g_chk_d1
      a_latency: assert property (@(posedge clk) disable iff ($time == 0)
         (seen_rst_q && !$past(reset)) |-> qout == $past(qin))
         else $error("flipflop: qout != previous qin at %0t", $time);
   end else begin : g_chk_dn
      a_latency: assert property (@(posedge clk) disable iff ($time == 0)
         (low_cnt_q >= DEPTH) |-> qout == $past(qin, DEPTH))
         else $error("flipflop: qout != qin delayed by DEPTH at %0t", $time);
   end

   a_known: assert property (@(posedge clk) disable iff ($time == 0)
      seen_rst_q |-> !$isunknown(qout))
      else $error("flipflop: qout unknown after reset at %0t", $time);
`endif
endmodule

// File: tb/tb_flipflop.sv
// Bench for flipflop: DEPTH=1 default and DEPTH=3/RESET_VAL=A5 side by side.
module tb_flipflop;
   import flipflop_pkg::*;

   logic  clk = 1'b0;
   logic  reset;
   data_t qin;
   data_t q1, q3;

   int n_cmp = 0;
   int n_err = 0;

   // Per-edge history of what each edge sampled.
   data_t qh[$];
   bit    rh[$];

   flipflop u_d1 (.clk(clk), .reset(reset), .qin(qin), .qout(q1));
   flipflop #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_d3 (
      .clk(clk), .reset(reset), .qin(qin), .qout(q3));

   always #5 clk = ~clk;

   // Output after the latest edge: the qin sampled D-1 edges ago, unless
   // any edge in that D-edge window was a reset edge.
   function automatic data_t model(input int d, input data_t rv);
      int k = qh.size() - 1;
      for (int j = 0; j < d; j++)
         if (rh[k-j]) return rv;
      return qh[k-d+1];
   endfunction

   task automatic chk(input string tag, input data_t obs, input data_t exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input data_t d);
      @(negedge clk);
      reset = r;
      qin   = d;
      @(posedge clk);
      qh.push_back(d);
      rh.push_back(r);
      #1;
      chk("model_d1", q1, model(1, 8'h00));
      if (qh.size() >= 3) chk("model_d3", q3, model(3, 8'hA5));
   endtask

   initial begin
      reset = 1'b1;
      qin   = 8'hFF;

      // Reset held for three edges with qin all ones.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'hFF);
         chk("rst_hold_d1", q1, 8'h00);
         chk("rst_hold_d3", q3, 8'hA5);
      end

      // Counting stream, visible right after the sampling edge at DEPTH=1.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'(i));
         chk("count_d1", q1, 8'(i));
      end

      // Mid-cycle glitch on qin must not reach qout.
      step(1'b0, 8'h3C);
      #2 qin = 8'hC3;
      #1 chk("glitch_d1", q1, 8'h3C);
      qin = 8'h3C;
      step(1'b0, 8'h3C);
      chk("glitch_hold_d1", q1, 8'h3C);

      // Reset in the middle of a stream discards in-flight data.
      step(1'b0, 8'h10);
      step(1'b0, 8'h11);
      step(1'b0, 8'h12);
      step(1'b1, 8'h13);
      chk("midrst_d1", q1, 8'h00);
      chk("midrst_d3", q3, 8'hA5);
      step(1'b0, 8'h20);
      chk("post_rst_d1", q1, 8'h20);

      // DEPTH=3: reset value drains before the first captured word.
      step(1'b1, 8'h00);
      step(1'b0, 8'h01);
      chk("drain0_d3", q3, 8'hA5);
      step(1'b0, 8'h02);
      chk("drain1_d3", q3, 8'hA5);
      step(1'b0, 8'h03);
      chk("drain2_d3", q3, 8'h01);
      step(1'b0, 8'h04);
      chk("drain3_d3", q3, 8'h02);
      step(1'b0, 8'h05);
      chk("drain4_d3", q3, 8'h03);

      // Random traffic with occasional resets.
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 11) == 0), data_t'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
